maxpool_relu_2x2: RTL and testbench

MAXPOOL_RELU_2X2 -- requirements
Module: maxpool_relu_2x2

---
 rtl/cnn_pkg.sv | 16 +
 rtl/pool_linebuf.sv | 29 ++
 rtl/maxpool_relu_2x2.sv | 103 ++++++++++
 tb/tb_maxpool_relu_2x2.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the conv-net pipeline stages.
//   T_DEF  : default data word width (two's complement signed)
//   wide_t : wide signed carrier so one max function serves every word width
//   smax   : signed maximum of two wide_t values
package cnn_pkg;

   localparam int T_DEF = 16;
   localparam int MAXW  = 64;

   typedef logic signed [MAXW-1:0] wide_t;

   function automatic wide_t smax(input wide_t a, input wide_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_linebuf.sv
// pool_linebuf: one-row buffer of pair maxima for the 2x2 pooler.
//   clk   : write clock
//   we    : write enable
//   waddr : write address (pair index col/2)
//   wdata : word written
//   raddr : read address (asynchronous read)
//   rdata : word read
// Not reset: every entry is written on an even row before the odd row reads it.
module pool_linebuf #(
   parameter int T  = 16,
   parameter int D  = 4,
   parameter int AW = (D > 1) ? $clog2(D) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [T-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [T-1:0]  rdata
);

   logic [T-1:0] mem [D];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_relu_2x2.sv
// maxpool_relu_2x2: streaming 2x2/stride-2 max pool fused with ReLU.
//   clk, reset       : clock, asynchronous active-high reset
//   x_data/valid/ready : input stream, channel-major then row-major then column
//   y_data/valid/ready : output stream, one word per 2x2 window, max(0, window)
// Even column words go to hold; odd column words in even rows store the pair
// maximum in the line buffer; odd column words in odd rows complete the
// window and load the single output register.
module maxpool_relu_2x2 import cnn_pkg::*; #(
   parameter int T   = T_DEF,
   parameter int R   = 8,
   parameter int C   = 8,
   parameter int NCH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [T-1:0] x_data,
   input  logic         x_valid,
   output logic         x_ready,
   output logic [T-1:0] y_data,
   output logic         y_valid,
   input  logic         y_ready
);

   localparam int CW = $clog2(C);
   localparam int RW = $clog2(R);
   localparam int HW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int D  = C / 2;
   localparam int AW = (D > 1) ? $clog2(D) : 1;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [HW-1:0] ch;
   logic [T-1:0]  hold;
   logic [T-1:0]  lb_rd;
   logic [T-1:0]  m_hx;
   logic [T-1:0]  m_win;
   logic [T-1:0]  m_out;
   logic [AW-1:0] lb_addr;
   logic          xfer;
   logic          lb_we;

   function automatic wide_t sx(input logic [T-1:0] v);
      return wide_t'($signed(v));
   endfunction

   function automatic logic [T-1:0] max2(input logic [T-1:0] a, input logic [T-1:0] b);
      return T'(smax(sx(a), sx(b)));
   endfunction

   // Loading is allowed whenever the output register is empty or draining.
   assign x_ready = !y_valid | y_ready;
   assign xfer    = x_valid & x_ready;

   assign lb_addr = AW'(col >> 1);
   assign lb_we   = xfer & col[0] & ~row[0];

   assign m_hx  = max2(hold, x_data);
   assign m_win = max2(m_hx, lb_rd);
   assign m_out = max2(m_win, '0);

   pool_linebuf #(.T(T), .D(D), .AW(AW)) u_lb (
      .clk   (clk),
      .we    (lb_we),
      .waddr (lb_addr),
      .wdata (m_hx),
      .raddr (lb_addr),
      .rdata (lb_rd)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col     <= '0;
         row     <= '0;
         ch      <= '0;
         hold    <= '0;
         y_valid <= 1'b0;
         y_data  <= '0;
      end else begin
         if (y_valid && y_ready) y_valid <= 1'b0;
         if (xfer) begin
            if (col == CW'(C-1)) begin
               col <= '0;
               if (row == RW'(R-1)) begin
                  row <= '0;
                  ch  <= (ch == HW'(NCH-1)) ? '0 : ch + HW'(1);
               end else begin
                  row <= row + RW'(1);
               end
            end else begin
               col <= col + CW'(1);
            end
            if (!col[0]) begin
               hold <= x_data;
            end else if (row[0]) begin
               // A new load wins over the drain clear above on the same edge.
               y_data  <= m_out;
               y_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_maxpool_relu_2x2.sv
// tb_maxpool_relu_2x2: directed bench for maxpool_relu_2x2.
// Two instances share the input stream: u_a (R=C=4, NCH=1) and u_b
// (R=C=4, NCH=2); sel chooses which one the driver and monitor follow.
module tb_maxpool_relu_2x2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] x_data = '0;
   logic        x_valid = 1'b0;
   logic        y_ready = 1'b1;
   logic        sel = 1'b0;
   bit          rnd = 1'b0;

   logic        xr_a, yv_a, xr_b, yv_b;
   logic [15:0] yd_a, yd_b;
   logic        xr_s, yv_s;
   logic [15:0] yd_s;

   int checks   = 0;
   int failures = 0;
   int stalls   = 0;

   logic [15:0] q[$];
   logic [15:0] expq[$];
   logic [15:0] fr[64];

   always #5 clk = ~clk;

   maxpool_relu_2x2 #(.T(16), .R(4), .C(4), .NCH(1)) u_a (
      .clk(clk), .reset(rst), .x_data(x_data), .x_valid(x_valid), .x_ready(xr_a),
      .y_data(yd_a), .y_valid(yv_a), .y_ready(y_ready));

   maxpool_relu_2x2 #(.T(16), .R(4), .C(4), .NCH(2)) u_b (
      .clk(clk), .reset(rst), .x_data(x_data), .x_valid(x_valid), .x_ready(xr_b),
      .y_data(yd_b), .y_valid(yv_b), .y_ready(y_ready));

   assign xr_s = sel ? xr_b : xr_a;
   assign yv_s = sel ? yv_b : yv_a;
   assign yd_s = sel ? yd_b : yd_a;

   always @(posedge clk)
      if (!rst && yv_s && y_ready) q.push_back(yd_s);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; x_valid = 1'b0; y_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      q.delete();
      expq.delete();
   endtask

   // Called at a negedge; returns at the negedge after the word is accepted.
   task automatic push(input logic [15:0] w);
      int n;
      if (rnd)
         while ($urandom_range(0, 2) == 0) begin
            x_valid = 1'b0; y_ready = 1'($urandom); @(negedge clk);
         end
      x_data = w; x_valid = 1'b1;
      if (rnd) y_ready = 1'($urandom);
      #1;
      n = 0;
      while (!xr_s && n < 200) begin
         stalls++;
         @(negedge clk);
         if (rnd) y_ready = 1'($urandom);
         #1;
         n++;
      end
      if (n >= 200) begin
         failures++;
         $display("FAIL push_timeout word=%h waited=%0d required<200", w, n);
      end
      @(negedge clk);
   endtask

   task automatic drain_cmp(input string tag);
      int k;
      x_valid = 1'b0; y_ready = 1'b1;
      k = 0;
      while (q.size() < expq.size() && k < 100) begin @(negedge clk); k++; end
      repeat (4) @(negedge clk);
      chk({tag, "_count"}, q.size(), expq.size());
      for (int i = 0; i < expq.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? {16'h0, q[i]} : 32'hDEAD_BEEF,
             {16'h0, expq[i]});
   endtask

   function automatic logic [15:0] smax16(input logic [15:0] a, input logic [15:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   initial begin
      // ---- reset state and basic ramp 0..15 ----
      sel = 1'b0;
      do_reset();
      #1;
      chk("rst_y_valid", yv_s, 0);
      chk("rst_x_ready", xr_s, 1);
      chk("rst_y_data",  yd_s, 0);
      stalls = 0;
      for (int i = 0; i < 16; i++) begin
         push(16'(i));
         if (i == 4) begin #1; chk("no_out_before_window", yv_s, 0); end
         if (i == 5) begin #1; chk("latency1_valid", yv_s, 1); chk("latency1_data", yd_s, 16'd5); end
      end
      chk("full_rate_stalls", stalls, 0);
      expq = '{16'd5, 16'd7, 16'd13, 16'd15};
      drain_cmp("ramp");

      // ---- all negative -> ReLU zeros ----
      do_reset();
      for (int i = 0; i < 16; i++) push(16'hFFFD);
      expq = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      drain_cmp("neg3");

      // ---- signed extremes and line-buffer maximum ----
      do_reset();
      begin
         logic [15:0] v[16];
         v = '{16'h8000, 16'h7FFF, 16'hFFFE, 16'hFFF9,
               16'hFFFF, 16'h0000, 16'h0003, 16'hFFFF,
               16'h0010, 16'h0001, 16'hFFFB, 16'hFFFB,
               16'h0002, 16'h0003, 16'hFFFB, 16'hFFFB};
         for (int i = 0; i < 16; i++) push(v[i]);
      end
      expq = '{16'h7FFF, 16'h0003, 16'h0010, 16'h0000};
      drain_cmp("extremes");

      // ---- backpressure: hold output for 10 cycles ----
      do_reset();
      for (int i = 0; i < 5; i++) push(16'(i));
      y_ready = 1'b0;
      push(16'd5);
      x_data = 16'd6; x_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk($sformatf("stall_x_ready[%0d]", k), xr_s, 0);
         chk($sformatf("stall_y_valid[%0d]", k), yv_s, 1);
         chk($sformatf("stall_y_data[%0d]", k), yd_s, 16'd5);
         @(negedge clk);
      end
      y_ready = 1'b1;
      for (int i = 6; i < 16; i++) push(16'(i));
      expq = '{16'd5, 16'd7, 16'd13, 16'd15};
      drain_cmp("stall");

      // ---- NCH=2, two frames, random valid/ready, golden model ----
      sel = 1'b1;
      do_reset();
      for (int i = 0; i < 64; i++) fr[i] = 16'($urandom);
      for (int f = 0; f < 2; f++)
         for (int c = 0; c < 2; c++)
            for (int i = 0; i < 2; i++)
               for (int j = 0; j < 2; j++) begin
                  int b;
                  logic [15:0] m;
                  b = f * 32 + c * 16 + (2 * i) * 4 + 2 * j;
                  m = smax16(smax16(fr[b], fr[b+1]), smax16(fr[b+4], fr[b+5]));
                  expq.push_back(smax16(m, 16'h0000));
               end
      rnd = 1'b1;
      for (int i = 0; i < 64; i++) push(fr[i]);
      rnd = 1'b0;
      drain_cmp("frames");

      // ---- reset mid-frame with a pending output ----
      sel = 1'b0;
      do_reset();
      y_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(16'h0100 + 16'(i));
      #1;
      chk("pre_reset_pending", yv_s, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_y_valid", yv_s, 0);
      chk("async_rst_x_ready", xr_s, 1);
      chk("async_rst_y_data",  yd_s, 0);
      x_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      y_ready = 1'b1;
      for (int i = 0; i < 16; i++) push(16'(15 - i));
      expq = '{16'd15, 16'd13, 16'd7, 16'd5};
      drain_cmp("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout reached time limit");
      $fatal(1, "timeout");
   end

endmodule
